clk_char_meter: RTL and testbench

- Synthesizable counterpart to the testbench clock generator: measures an incoming clock-like signal instead of producing one.
- Given a start pulse, reports high time, low time, period, and phase offset of `sig_in` relative to `ref_in`, all in `clk` cycles.
- Used in benches and on-chip self-test to check generated clocks against their frequency, duty and phase settings.

---
 rtl/clk_char_meter.sv | 228 ++++++++++++++++++++++
 tb/tb_clk_char_meter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_char_meter.sv
// Clock characterisation meter: measures phase, high, low and period of sig_in in clk cycles.
// Define DUTY_CALC_EN to add a 7-cycle restoring divider that reports duty_pct.
`timescale 1ns/1ps

module clk_char_meter #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sig_in,
   input  logic             ref_in,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] phase_cnt,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] low_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic [6:0]       duty_pct
);

   typedef enum logic [2:0] {
      StIdle,
      StWaitRef,
      StPhase,
      StHigh,
      StLow,
`ifdef DUTY_CALC_EN
      StDiv,
`endif
      StFin
   } state_e;

   state_e state_q;

   logic [SYNC_STAGES-1:0] sig_sync_q;
   logic [SYNC_STAGES-1:0] ref_sync_q;
   logic                   sig_dly_q;
   logic                   ref_dly_q;
   logic                   sig_s;
   logic                   ref_s;
   logic                   sig_rise;
   logic                   sig_fall;
   logic                   ref_rise;

   logic [CNT_W-1:0] cnt_q;
   logic             cnt_sat;
   logic [CNT_W:0]   period_sum;
   logic [CNT_W-1:0] period_next;

   // Both inputs share the same pipeline depth so the phase result carries no bias.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_sync_q <= '0;
         ref_sync_q <= '0;
         sig_dly_q  <= 1'b0;
         ref_dly_q  <= 1'b0;
      end else begin
         sig_sync_q <= {sig_sync_q[SYNC_STAGES-2:0], sig_in};
         ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], ref_in};
         sig_dly_q  <= sig_sync_q[SYNC_STAGES-1];
         ref_dly_q  <= ref_sync_q[SYNC_STAGES-1];
      end
   end

   assign sig_s    = sig_sync_q[SYNC_STAGES-1];
   assign ref_s    = ref_sync_q[SYNC_STAGES-1];
   assign sig_rise = sig_s & ~sig_dly_q;
   assign sig_fall = ~sig_s & sig_dly_q;
   assign ref_rise = ref_s & ~ref_dly_q;

   assign cnt_sat     = (cnt_q == '1);
   assign period_sum  = {1'b0, high_cnt} + {1'b0, cnt_q};
   assign period_next = period_sum[CNT_W] ? '1 : period_sum[CNT_W-1:0];

`ifdef DUTY_CALC_EN
   localparam int unsigned DW = CNT_W + 7;

   logic [DW-1:0]    rem_q;
   logic [CNT_W-1:0] dvs_q;
   logic [2:0]       bit_q;
   logic [5:0]       quo_q;
   logic [DW-1:0]    div_trial;
   logic             div_ge;

   // Quotient never exceeds 100, so a 7-bit restoring divide from bit 6 down is exact.
   assign div_trial = DW'(dvs_q) << bit_q;
   assign div_ge    = (rem_q >= div_trial);
`else
   assign duty_pct = 7'd0;
`endif

   // The counter is loaded with 1 on a starting edge, so at the ending edge it holds
   // exactly the number of cycles between the two detections.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         phase_cnt  <= '0;
         high_cnt   <= '0;
         low_cnt    <= '0;
         period_cnt <= '0;
`ifdef DUTY_CALC_EN
         duty_pct   <= 7'd0;
         rem_q      <= '0;
         dvs_q      <= '0;
         bit_q      <= 3'd0;
         quo_q      <= 6'd0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StWaitRef;
                  busy    <= 1'b1;
                  timeout <= 1'b0;
               end
            end
            StWaitRef: begin
               if (ref_rise) begin
                  cnt_q <= CNT_W'(1);
                  if (sig_rise) begin
                     phase_cnt <= '0;
                     state_q   <= StHigh;
                  end else begin
                     state_q <= StPhase;
                  end
               end
            end
            StPhase: begin
               if (sig_rise) begin
                  phase_cnt <= cnt_q;
                  cnt_q     <= CNT_W'(1);
                  state_q   <= StHigh;
               end else if (cnt_sat) begin
                  phase_cnt <= cnt_q;
                  timeout   <= 1'b1;
                  done      <= 1'b1;
                  state_q   <= StFin;
`ifdef DUTY_CALC_EN
                  duty_pct  <= 7'd0;
`endif
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StHigh: begin
               if (sig_fall) begin
                  high_cnt <= cnt_q;
                  cnt_q    <= CNT_W'(1);
                  state_q  <= StLow;
               end else if (cnt_sat) begin
                  high_cnt <= cnt_q;
                  timeout  <= 1'b1;
                  done     <= 1'b1;
                  state_q  <= StFin;
`ifdef DUTY_CALC_EN
                  duty_pct <= 7'd0;
`endif
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            StLow: begin
               if (sig_rise) begin
                  low_cnt    <= cnt_q;
                  period_cnt <= period_next;
`ifdef DUTY_CALC_EN
                  if (period_next == '0) begin
                     duty_pct <= 7'd0;
                     done     <= 1'b1;
                     state_q  <= StFin;
                  end else begin
                     rem_q   <= DW'(high_cnt) * DW'(100);
                     dvs_q   <= period_next;
                     bit_q   <= 3'd6;
                     quo_q   <= 6'd0;
                     state_q <= StDiv;
                  end
`else
                  done    <= 1'b1;
                  state_q <= StFin;
`endif
               end else if (cnt_sat) begin
                  low_cnt <= cnt_q;
                  timeout <= 1'b1;
                  done    <= 1'b1;
                  state_q <= StFin;
`ifdef DUTY_CALC_EN
                  duty_pct <= 7'd0;
`endif
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
`ifdef DUTY_CALC_EN
            StDiv: begin
               if (div_ge) begin
                  rem_q <= rem_q - div_trial;
               end
               quo_q <= {quo_q[4:0], div_ge};
               if (bit_q == 3'd0) begin
                  duty_pct <= {quo_q, div_ge};
                  done     <= 1'b1;
                  state_q  <= StFin;
               end else begin
                  bit_q <= bit_q - 3'd1;
               end
            end
`endif
            StFin: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clk_char_meter.sv
// Directed bench for clk_char_meter: table of periodic input shapes plus timeout,
// restart-while-busy and mid-measurement reset sequences.
`timescale 1ns/1ps

module tb_clk_char_meter;

`ifdef DUTY_CALC_EN
   localparam int DUTY_ON = 1;
   localparam int LAT     = 10;
`else
   localparam int DUTY_ON = 0;
   localparam int LAT     = 3;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        start8;
   logic        sig_in;
   logic        ref_in;
   logic        sig8;
   logic        busy, done, timeout;
   logic [15:0] phase_cnt, high_cnt, low_cnt, period_cnt;
   logic [6:0]  duty_pct;
   logic        busy8, done8, timeout8;
   logic [7:0]  phase8, high8, low8, period8;
   logic [6:0]  duty8;

   // Generator controls, written only by the main sequence.
   int          gen_p = 10;
   int          gen_h = 3;
   int          gen_l = 2;
   bit          sig8_stuck = 1'b1;
   int          ph;
   logic        prev_sig;
   logic [15:0] hist;

   bit          sel8 = 1'b0;
   logic        m_busy, m_done, m_timeout;
   logic [15:0] m_phase, m_high, m_low, m_period;
   logic [6:0]  m_duty;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      int p;
      int h;
      int l;
      int e_ph;
      int e_hi;
      int e_lo;
      int e_per;
      int e_duty;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;

   clk_char_meter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .sig_in     (sig_in),
      .ref_in     (ref_in),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout),
      .phase_cnt  (phase_cnt),
      .high_cnt   (high_cnt),
      .low_cnt    (low_cnt),
      .period_cnt (period_cnt),
      .duty_pct   (duty_pct)
   );

   clk_char_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
      .clk        (clk),
      .rst        (rst),
      .start      (start8),
      .sig_in     (sig8),
      .ref_in     (ref_in),
      .busy       (busy8),
      .done       (done8),
      .timeout    (timeout8),
      .phase_cnt  (phase8),
      .high_cnt   (high8),
      .low_cnt    (low8),
      .period_cnt (period8),
      .duty_pct   (duty8)
   );

   assign m_busy    = sel8 ? busy8 : busy;
   assign m_done    = sel8 ? done8 : done;
   assign m_timeout = sel8 ? timeout8 : timeout;
   assign m_phase   = sel8 ? {8'h00, phase8} : phase_cnt;
   assign m_high    = sel8 ? {8'h00, high8} : high_cnt;
   assign m_low     = sel8 ? {8'h00, low8} : low_cnt;
   assign m_period  = sel8 ? {8'h00, period8} : period_cnt;
   assign m_duty    = sel8 ? duty8 : duty_pct;

   // Cycle-based waveform source; edges land on the falling clock edge.
   // hist[k] is set when sig_in rose k falling edges ago.
   initial begin
      ph       = 0;
      ref_in   = 1'b0;
      sig_in   = 1'b0;
      sig8     = 1'b0;
      prev_sig = 1'b0;
      hist     = '0;
      forever begin
         @(negedge clk);
         ph       = (ph + 1 >= gen_p) ? 0 : ph + 1;
         ref_in   = (ph < gen_h);
         sig_in   = (((ph + gen_p - gen_l) % gen_p) < gen_h);
         sig8     = sig8_stuck ? 1'b0 : sig_in;
         hist     = {hist[14:0], sig_in & ~prev_sig};
         prev_sig = sig_in;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d, required %0d", nm, act, exp);
      end
   endtask

   task automatic set_mode(input int p, input int h, input int l);
      gen_p = p;
      gen_h = h;
      gen_l = l;
      repeat (2 * p + 6) @(negedge clk);
   endtask

   task automatic pulse_start(input bit use8);
      @(negedge clk);
      #1;
      if (use8) start8 = 1'b1;
      else start = 1'b1;
      @(negedge clk);
      #1;
      start  = 1'b0;
      start8 = 1'b0;
   endtask

   task automatic measure(input string nm, input bit use8, input int e_ph, input int e_hi,
                          input int e_lo, input int e_per, input int e_duty, input bit e_to,
                          input bit chk_lat, input int restart_at);
      int   ndone;
      int   post;
      bit   seen;
      logic lat_hit;
      sel8 = use8;
      pulse_start(use8);
      chk({nm, "/busy_after_start"}, 32'(m_busy), 32'd1);
      ndone   = 0;
      post    = 0;
      seen    = 1'b0;
      lat_hit = 1'b0;
      for (int c = 0; c < 700 && post < 12; c++) begin
         if (c == restart_at) begin
            if (use8) start8 = 1'b1;
            else start = 1'b1;
         end else if (c == restart_at + 1) begin
            start  = 1'b0;
            start8 = 1'b0;
         end
         @(negedge clk);
         #1;
         if (m_done) begin
            ndone++;
            if (!seen) begin
               seen    = 1'b1;
               lat_hit = hist[LAT];
            end
         end
         if (seen) post++;
      end
      start  = 1'b0;
      start8 = 1'b0;
      chk({nm, "/done_count"}, 32'(ndone), 32'd1);
      if (chk_lat && seen) chk({nm, "/done_latency"}, 32'(lat_hit), 32'd1);
      chk({nm, "/busy_idle"}, 32'(m_busy), 32'd0);
      chk({nm, "/timeout"}, 32'(m_timeout), 32'(e_to));
      chk({nm, "/phase"}, 32'(m_phase), 32'(e_ph));
      chk({nm, "/high"}, 32'(m_high), 32'(e_hi));
      chk({nm, "/low"}, 32'(m_low), 32'(e_lo));
      chk({nm, "/period"}, 32'(m_period), 32'(e_per));
      chk({nm, "/duty"}, 32'(m_duty), 32'(e_duty * DUTY_ON));
   endtask

   initial begin
      int  n;
      bit  found;

      // period, high, ref lead, then expected phase/high/low/period/duty
      vecs[0] = '{10, 3, 2, 2, 3, 7, 10, 30};
      vecs[1] = '{10, 3, 0, 0, 3, 7, 10, 30};
      vecs[2] = '{4, 2, 1, 1, 2, 2, 4, 50};
      vecs[3] = '{20, 15, 5, 5, 15, 5, 20, 75};
      vecs[4] = '{7, 1, 3, 3, 1, 6, 7, 14};

      rst    = 1'b1;
      start  = 1'b0;
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset/busy", 32'(busy), 32'd0);
      chk("reset/done", 32'(done), 32'd0);
      chk("reset/timeout", 32'(timeout), 32'd0);
      chk("reset/phase", 32'(phase_cnt), 32'd0);
      chk("reset/high", 32'(high_cnt), 32'd0);
      chk("reset/low", 32'(low_cnt), 32'd0);
      chk("reset/period", 32'(period_cnt), 32'd0);
      chk("reset/duty", 32'(duty_pct), 32'd0);
      chk("reset/busy8", 32'(busy8), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         set_mode(vecs[i].p, vecs[i].h, vecs[i].l);
         measure($sformatf("vec%0d", i), 1'b0, vecs[i].e_ph, vecs[i].e_hi, vecs[i].e_lo,
                 vecs[i].e_per, vecs[i].e_duty, 1'b0, 1'b1, -1);
      end

      // Second start while busy must be ignored.
      set_mode(10, 3, 2);
      measure("restart", 1'b0, 2, 3, 7, 10, 30, 1'b0, 1'b1, 5);

      // 8-bit instance: sig stuck low saturates in PHASE, then a clean run clears timeout.
      sig8_stuck = 1'b1;
      set_mode(10, 3, 2);
      measure("sat8", 1'b1, 255, 0, 0, 0, 0, 1'b1, 1'b0, -1);
      sig8_stuck = 1'b0;
      set_mode(10, 3, 2);
      measure("after_sat8", 1'b1, 2, 3, 7, 10, 30, 1'b0, 1'b1, -1);
      sel8 = 1'b0;
      chk("sat8/main_timeout", 32'(timeout), 32'd0);

      // Reset while in HIGH: outputs clear immediately and no done follows.
      pulse_start(1'b0);
      found = 1'b0;
      for (int c = 1; c < 200 && !found; c++) begin
         @(negedge clk);
         #1;
         if (c >= 4 && busy && !done && hist[3]) found = 1'b1;
      end
      chk("rst_high/reached", 32'(found), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_high/busy", 32'(busy), 32'd0);
      chk("rst_high/done", 32'(done), 32'd0);
      chk("rst_high/phase", 32'(phase_cnt), 32'd0);
      chk("rst_high/high", 32'(high_cnt), 32'd0);
      chk("rst_high/low", 32'(low_cnt), 32'd0);
      chk("rst_high/period", 32'(period_cnt), 32'd0);
      chk("rst_high/phase8", 32'(phase8), 32'd0);
      @(negedge clk);
      #1;
      rst = 1'b0;
      n = 0;
      repeat (30) begin
         @(negedge clk);
         #1;
         if (done) n++;
      end
      chk("rst_high/no_done", 32'(n), 32'd0);
      measure("post_rst", 1'b0, 2, 3, 7, 10, 30, 1'b0, 1'b1, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
